dae_issue_writeback: RTL and testbench



---
 rtl/dae_issue_writeback_pkg.sv | 34 +++
 rtl/dae_regfile.sv | 47 ++++
 rtl/dae_issue_writeback.sv | 102 ++++++++++
 tb/tb_dae_issue_writeback.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dae_issue_writeback_pkg.sv
// Shared definitions for the issue/write-back wrapper around the execute unit:
// data and index widths, instruction field positions, FSM encoding and the
// register reset-value rule.
package dae_issue_writeback_pkg;

   localparam int DATA_W  = 4;
   localparam int REG_N   = 4;
   localparam int IDX_W   = 2;
   localparam int INSTR_W = 10;
   localparam int OP_W    = 3;

   // Instruction layout: {ld, op[2:0], dst[1:0], sa[1:0], sb[1:0]}
   localparam int LD_BIT  = 9;
   localparam int OP_MSB  = 8;
   localparam int OP_LSB  = 6;
   localparam int DST_MSB = 5;
   localparam int DST_LSB = 4;
   localparam int SA_MSB  = 3;
   localparam int SA_LSB  = 2;
   localparam int SB_MSB  = 1;
   localparam int SB_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   // Each register comes out of reset holding its own index (R0=0 .. R3=3).
   function automatic logic [DATA_W-1:0] reg_reset_value(input logic [IDX_W-1:0] idx);
      return DATA_W'(idx);
   endfunction

endpackage

// File: rtl/dae_regfile.sv
// 4 x 4-bit register file: two registered read ports that load only when
// rd_en is high (so they hold their value otherwise), one write port and a
// combinational debug read port.
module dae_regfile
   import dae_issue_writeback_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_addr_a,
   input  logic [IDX_W-1:0]  rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] regs [REG_N];

   // Storage array: reset to index values, single write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_N; i++) begin
            regs[i] <= reg_reset_value(IDX_W'(i));
         end
      end else if (we) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Registered read ports: capture operands when asked, otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else if (rd_en) begin
         rd_data_a <= regs[rd_addr_a];
         rd_data_b <= regs[rd_addr_b];
      end
   end

   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/dae_issue_writeback.sv
// Single-issue wrapper around the combinational execute unit. An instruction
// is accepted in IDLE, its operands are presented to the execute unit during
// EXEC, and the result (or the load immediate) is written back on leaving WB.
// Only one instruction is ever in flight, so no hazard logic is needed.
module dae_issue_writeback
   import dae_issue_writeback_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   output logic [DATA_W-1:0]  ex_rs,
   output logic [DATA_W-1:0]  ex_rt,
   output logic [OP_W-1:0]    ex_sel,
   input  logic [DATA_W-1:0]  ex_rd,
   output logic               wb_valid,
   output logic [IDX_W-1:0]   wb_idx,
   output logic [DATA_W-1:0]  wb_data,
   input  logic [IDX_W-1:0]   dbg_idx,
   output logic [DATA_W-1:0]  dbg_data,
   output logic [CNT_W-1:0]   retired
);

   state_t            state;
   logic              ld_q;
   logic [IDX_W-1:0]  dst_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] result_q;
   logic              accept;
   logic              wb_we;
   logic [DATA_W-1:0] wb_value;

   assign in_ready = (state == IDLE);
   assign accept   = in_ready && in_valid;
   assign wb_we    = (state == WB);
   assign wb_value = ld_q ? imm_q : result_q;

   // Operands are read on the accept edge so they are stable for all of EXEC;
   // a write from the previous instruction has already landed by then.
   dae_regfile u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (accept),
      .rd_addr_a (in_instr[SA_MSB:SA_LSB]),
      .rd_addr_b (in_instr[SB_MSB:SB_LSB]),
      .rd_data_a (ex_rs),
      .rd_data_b (ex_rt),
      .we        (wb_we),
      .wr_addr   (dst_q),
      .wr_data   (wb_value),
      .dbg_addr  (dbg_idx),
      .dbg_data  (dbg_data)
   );

   // Issue FSM with registered execute-select, write-back pulse and retire counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ld_q     <= 1'b0;
         dst_q    <= '0;
         imm_q    <= '0;
         result_q <= '0;
         ex_sel   <= '0;
         wb_valid <= 1'b0;
         wb_idx   <= '0;
         wb_data  <= '0;
         retired  <= '0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ld_q   <= in_instr[LD_BIT];
                  dst_q  <= in_instr[DST_MSB:DST_LSB];
                  imm_q  <= in_instr[SA_MSB:SB_LSB];
                  ex_sel <= in_instr[OP_MSB:OP_LSB];
                  state  <= EXEC;
               end
            end
            EXEC: begin
               result_q <= ex_rd;
               state    <= WB;
            end
            WB: begin
               wb_valid <= 1'b1;
               wb_idx   <= dst_q;
               wb_data  <= wb_value;
               retired  <= retired + CNT_W'(1);
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dae_issue_writeback.sv
// Bench for dae_issue_writeback: a stub execute unit, a table of directed
// instructions, a mid-operation reset sequence and a randomized run checked
// against an array-based model of the register file.
module tb_dae_issue_writeback;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] in_instr;
   logic [3:0] ex_rs;
   logic [3:0] ex_rt;
   logic [2:0] ex_sel;
   logic [3:0] ex_rd;
   logic       wb_valid;
   logic [1:0] wb_idx;
   logic [3:0] wb_data;
   logic [1:0] dbg_idx;
   logic [3:0] dbg_data;
   logic [7:0] retired;

   int checks = 0;
   int errors = 0;
   bit stubAlu = 1'b0;
   logic [7:0] expRetired = 8'd0;
   logic [3:0] mreg [4];

   typedef struct {
      logic [9:0] instr;
      logic [3:0] rs;
      logic [3:0] rt;
      logic [3:0] data;
   } vec_t;

   vec_t tableV [8];

   dae_issue_writeback #(.CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_instr (in_instr),
      .ex_rs    (ex_rs),
      .ex_rt    (ex_rt),
      .ex_sel   (ex_sel),
      .ex_rd    (ex_rd),
      .wb_valid (wb_valid),
      .wb_idx   (wb_idx),
      .wb_data  (wb_data),
      .dbg_idx  (dbg_idx),
      .dbg_data (dbg_data),
      .retired  (retired)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behaviour of the stub execute unit, selected by op.
   function automatic logic [3:0] aluRef(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b);
      case (sel)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return {a[2:0], 1'b0};
         default: return b;
      endcase
   endfunction

   // Stub execute unit: plain adder for directed tests, small ALU for random ones.
   always_comb begin
      ex_rd = ex_rs + ex_rt;
      if (stubAlu) ex_rd = aluRef(ex_sel, ex_rs, ex_rt);
   end

   // Watchdog so a stuck design still ends the run.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkReg(input logic [1:0] idx, input logic [3:0] expected);
      dbg_idx = idx;
      #1;
      checkOutput($sformatf("dbg_data[%0d]", idx), dbg_data, expected);
   endtask

   task automatic applyReset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_instr = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      expRetired = 8'd0;
      for (int i = 0; i < 4; i++) mreg[i] = 4'(i);
   endtask

   // Issue one instruction and follow it through EXEC and WB. With hold set,
   // in_valid stays high and in_instr is scrambled while the block is busy.
   task automatic applyStimulus(input logic [9:0] instr, input logic [3:0] expRs,
                                input logic [3:0] expRt, input logic [3:0] expData,
                                input bit hold);
      int budget;
      logic [2:0] expSel;
      logic [1:0] expIdx;
      expSel = instr[8:6];
      expIdx = instr[5:4];
      budget = 0;
      while (!in_ready && budget < 8) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (!in_ready) checkOutput("wait_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_instr = instr;
      @(posedge clk);
      #1;
      if (hold) in_instr = 10'($urandom);
      else in_valid = 1'b0;
      checkOutput("exec_in_ready", in_ready, 0);
      checkOutput("exec_ex_rs", ex_rs, expRs);
      checkOutput("exec_ex_rt", ex_rt, expRt);
      checkOutput("exec_ex_sel", ex_sel, expSel);
      checkOutput("exec_wb_valid", wb_valid, 0);
      @(posedge clk);
      #1;
      if (hold) in_instr = 10'($urandom);
      checkOutput("wb_in_ready", in_ready, 0);
      checkOutput("wb_state_wb_valid", wb_valid, 0);
      @(posedge clk);
      #1;
      expRetired = expRetired + 8'd1;
      checkOutput("wb_valid", wb_valid, 1);
      checkOutput("wb_idx", wb_idx, expIdx);
      checkOutput("wb_data", wb_data, expData);
      checkOutput("retired", retired, expRetired);
      checkOutput("idle_in_ready", in_ready, 1);
      checkReg(expIdx, expData);
   endtask

   initial begin
      logic [9:0] instr;
      logic [3:0] rs;
      logic [3:0] rt;
      logic [3:0] data;
      bit hold;
      int gap;

      tableV[0] = '{10'b0_011_11_01_10, 4'd1,  4'd2,  4'd3};
      tableV[1] = '{10'b1_000_10_11_01, 4'd3,  4'd1,  4'd13};
      tableV[2] = '{10'b0_000_00_11_11, 4'd3,  4'd3,  4'd6};
      tableV[3] = '{10'b0_000_01_00_00, 4'd6,  4'd6,  4'd12};
      tableV[4] = '{10'b1_101_10_11_11, 4'd3,  4'd3,  4'd15};
      tableV[5] = '{10'b1_111_01_00_01, 4'd6,  4'd12, 4'd1};
      tableV[6] = '{10'b0_010_11_10_01, 4'd15, 4'd1,  4'd0};
      tableV[7] = '{10'b0_110_01_01_01, 4'd1,  4'd1,  4'd2};

      dbg_idx = 2'd0;
      stubAlu = 1'b0;

      // Reset state
      applyReset();
      checkOutput("reset_in_ready", in_ready, 1);
      checkOutput("reset_retired", retired, 0);
      checkOutput("reset_wb_valid", wb_valid, 0);
      checkOutput("reset_ex_rs", ex_rs, 0);
      checkOutput("reset_ex_sel", ex_sel, 0);
      for (int i = 0; i < 4; i++) checkReg(2'(i), 4'(i));

      // Directed table, back-to-back with in_valid held high
      for (int i = 0; i < 8; i++) begin
         applyStimulus(tableV[i].instr, tableV[i].rs, tableV[i].rt, tableV[i].data, 1'b1);
      end
      in_valid = 1'b0;
      checkReg(2'd0, 4'd6);
      checkReg(2'd1, 4'd2);
      checkReg(2'd2, 4'd15);
      checkReg(2'd3, 4'd0);

      // Reset during EXEC of R1 := 9 discards the instruction
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_instr = 10'b1_000_01_10_01;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("midrst_exec_in_ready", in_ready, 0);
      rst = 1'b1;
      #1;
      checkOutput("midrst_async_in_ready", in_ready, 1);
      checkOutput("midrst_async_ex_rs", ex_rs, 0);
      repeat (2) begin
         @(posedge clk);
         #1;
         checkOutput("midrst_hold_wb_valid", wb_valid, 0);
      end
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         checkOutput("midrst_after_wb_valid", wb_valid, 0);
         checkOutput("midrst_after_in_ready", in_ready, 1);
      end
      checkOutput("midrst_retired", retired, 0);
      for (int i = 0; i < 4; i++) checkReg(2'(i), 4'(i));
      expRetired = 8'd0;
      for (int i = 0; i < 4; i++) mreg[i] = 4'(i);

      // Randomized run against the register-array model; 256 retirements wrap the counter
      stubAlu = 1'b1;
      for (int n = 0; n < 256; n++) begin
         instr = 10'($urandom);
         rs    = mreg[instr[3:2]];
         rt    = mreg[instr[1:0]];
         data  = instr[9] ? instr[3:0] : aluRef(instr[8:6], rs, rt);
         hold  = bit'($urandom_range(0, 1));
         applyStimulus(instr, rs, rt, data, hold);
         mreg[instr[5:4]] = data;
         if (!hold) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               @(posedge clk);
               #1;
               checkOutput("gap_in_ready", in_ready, 1);
               checkOutput("gap_wb_valid", wb_valid, 0);
               checkOutput("gap_ex_rs_hold", ex_rs, rs);
            end
         end
      end
      in_valid = 1'b0;
      checkOutput("retired_wrap", retired, 0);
      for (int i = 0; i < 4; i++) checkReg(2'(i), mreg[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
